// File: rtl/intercpu_sb_write_arb.sv
// rtl/intercpu_sb_write_arb.sv - shared-B register clusters with a round-robin single write port
// Up to four CPUs request "SBj <- Ai"; one winner per clock, results visible the next cycle.
module intercpu_sb_write_arb #(
  parameter int NCPU   = 2,
  parameter int NCLUST = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   i_req,
  input  logic [11:0]  i_cln,
  input  logic [11:0]  i_j,
  input  logic [95:0]  i_ai,
  output logic [3:0]   o_ack,
  output logic [191:0] o_sb_1,
  output logic [191:0] o_sb_2,
  output logic [191:0] o_sb_3,
  output logic [191:0] o_sb_4,
  output logic [191:0] o_sb_5,
  output logic         o_busy
);

  logic [23:0]  r_sb [0:4][0:7];
  logic [1:0]   r_ptr;
  logic [3:0]   w_elig;
  logic [2:0]   w_cnt;
  logic         w_found;
  logic [1:0]   w_win;
  logic [2:0]   w_cln;
  logic [2:0]   w_j;
  logic [23:0]  w_ai;
  logic         w_cln_ok;
  logic [2:0]   w_cidx;
  logic [191:0] w_flat [0:4];
  int           v_idx;

  // A lane still showing its ack is masked so a held request is not written twice.
  for (genvar gk = 0; gk < 4; gk++) begin : g_elig
    assign w_elig[gk] = (gk < NCPU) && i_req[gk] && !o_ack[gk];
  end

  always_comb begin
    w_cnt = '0;
    for (int k = 0; k < 4; k++) w_cnt = w_cnt + {2'b00, w_elig[k]};
  end

  assign o_busy = (w_cnt >= 3'd2);

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    v_idx   = 0;
    for (int off = 0; off < NCPU; off++) begin
      v_idx = int'(r_ptr) + off;
      if (v_idx >= NCPU) v_idx = v_idx - NCPU;
      if (!w_found && w_elig[v_idx[1:0]]) begin
        w_found = 1'b1;
        w_win   = v_idx[1:0];
      end
    end
  end

  always_comb begin
    w_cln = i_cln[2:0];
    w_j   = i_j[2:0];
    w_ai  = i_ai[23:0];
    for (int k = 1; k < 4; k++) begin
      if (w_win == 2'(k)) begin
        w_cln = i_cln[3*k +: 3];
        w_j   = i_j[3*k +: 3];
        w_ai  = i_ai[24*k +: 24];
      end
    end
  end

  assign w_cln_ok = (w_cln != 3'd0) && (int'(w_cln) <= NCLUST);
  assign w_cidx   = w_cln - 3'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 5; c++)
        for (int j = 0; j < 8; j++)
          r_sb[c][j] <= '0;
      o_ack <= '0;
      r_ptr <= '0;
    end else begin
      o_ack <= '0;
      if (w_found) begin
        o_ack[w_win] <= 1'b1;
        r_ptr        <= (int'(w_win) + 1 >= NCPU) ? 2'd0 : w_win + 2'd1;
        if (w_cln_ok) r_sb[w_cidx][w_j] <= w_ai;
      end
    end
  end

  always_comb begin
    w_flat = '{default: '0};
    for (int c = 0; c < 5; c++)
      for (int j = 0; j < 8; j++)
        w_flat[c][24*j +: 24] = (c < NCLUST) ? r_sb[c][j] : 24'd0;
  end

  assign o_sb_1 = w_flat[0];
  assign o_sb_2 = w_flat[1];
  assign o_sb_3 = w_flat[2];
  assign o_sb_4 = w_flat[3];
  assign o_sb_5 = w_flat[4];

endmodule

// File: tb/tb_intercpu_sb_write_arb.sv
// tb/tb_intercpu_sb_write_arb.sv - vector table with ack scoreboard and SB reference image
module tb_intercpu_sb_write_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   i_req;
  logic [11:0]  i_cln;
  logic [11:0]  i_j;
  logic [95:0]  i_ai;
  logic [3:0]   o_ack;
  logic [191:0] o_sb_1, o_sb_2, o_sb_3, o_sb_4, o_sb_5;
  logic         o_busy;

  intercpu_sb_write_arb #(.NCPU(2), .NCLUST(5)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_cln(i_cln), .i_j(i_j), .i_ai(i_ai),
    .o_ack(o_ack), .o_sb_1(o_sb_1), .o_sb_2(o_sb_2), .o_sb_3(o_sb_3),
    .o_sb_4(o_sb_4), .o_sb_5(o_sb_5), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [11:0] cln;
    logic [11:0] j;
    logic [95:0] ai;
    logic        busy;
    logic [3:0]  ack;
  } vec_t;

  vec_t        tbl [19];
  logic [3:0]  ack_q [$];
  logic [23:0] m_sb [1:5][0:7];
  int          n_pass = 0;
  int          n_total = 0;

  function automatic vec_t mk(input logic [3:0] req,
                              input logic [2:0] c0, input logic [2:0] j0, input logic [23:0] a0,
                              input logic [2:0] c1, input logic [2:0] j1, input logic [23:0] a1,
                              input logic busy, input logic [3:0] ack);
    vec_t v;
    v.req  = req;
    v.cln  = {6'd0, c1, c0};
    v.j    = {6'd0, j1, j0};
    v.ai   = {48'd0, a1, a0};
    v.busy = busy;
    v.ack  = ack;
    return v;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [191:0] model_flat(input int c);
    logic [191:0] f;
    for (int j = 0; j < 8; j++) f[24*j +: 24] = m_sb[c][j];
    return f;
  endfunction

  function automatic logic [191:0] dut_sb(input int c);
    case (c)
      1: return o_sb_1;
      2: return o_sb_2;
      3: return o_sb_3;
      4: return o_sb_4;
      default: return o_sb_5;
    endcase
  endfunction

  task automatic clear_model();
    for (int c = 1; c <= 5; c++)
      for (int j = 0; j < 8; j++) m_sb[c][j] = 24'd0;
  endtask

  task automatic model_commit(input logic [3:0] ack, input vec_t v);
    logic [2:0] c;
    for (int k = 0; k < 4; k++) begin
      if (ack[k]) begin
        c = v.cln[3*k +: 3];
        if (c >= 3'd1 && c <= 3'd5) m_sb[int'(c)][int'(v.j[3*k +: 3])] = v.ai[24*k +: 24];
      end
    end
  endtask

  task automatic chk_sb(input string tag);
    for (int c = 1; c <= 5; c++) chk($sformatf("%s sb_%0d", tag, c), dut_sb(c), model_flat(c));
  endtask

  task automatic drive(input vec_t v);
    i_req = v.req;
    i_cln = v.cln;
    i_j   = v.j;
    i_ai  = v.ai;
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    logic [3:0] exp_ack;

    idle = mk(4'b0000, 3'd0, 3'd0, 24'd0, 3'd0, 3'd0, 24'd0, 1'b0, 4'b0000);
    tbl[0]  = mk(4'b0001, 3'd1, 3'd3, 24'hABCDEF, 3'd0, 3'd0, 24'd0,      1'b0, 4'b0001);
    tbl[1]  = idle;
    tbl[2]  = mk(4'b0010, 3'd0, 3'd0, 24'd0,      3'd0, 3'd2, 24'hFFFFFF, 1'b0, 4'b0010);
    tbl[3]  = idle;
    tbl[4]  = mk(4'b0010, 3'd0, 3'd0, 24'd0,      3'd6, 3'd2, 24'hFFFFFF, 1'b0, 4'b0010);
    tbl[5]  = idle;
    tbl[6]  = mk(4'b0011, 3'd2, 3'd0, 24'h000111, 3'd2, 3'd7, 24'h777000, 1'b1, 4'b0001);
    tbl[7]  = mk(4'b0010, 3'd2, 3'd0, 24'h000111, 3'd2, 3'd7, 24'h777000, 1'b0, 4'b0010);
    tbl[8]  = idle;
    tbl[9]  = mk(4'b0001, 3'd3, 3'd1, 24'h123456, 3'd0, 3'd0, 24'd0,      1'b0, 4'b0001);
    tbl[10] = idle;
    tbl[11] = mk(4'b0011, 3'd5, 3'd4, 24'h111111, 3'd5, 3'd4, 24'h222222, 1'b1, 4'b0010);
    tbl[12] = mk(4'b0001, 3'd5, 3'd4, 24'h111111, 3'd5, 3'd4, 24'h222222, 1'b0, 4'b0001);
    tbl[13] = idle;
    tbl[14] = mk(4'b0001, 3'd4, 3'd6, 24'h00ABCD, 3'd0, 3'd0, 24'd0,      1'b0, 4'b0001);
    tbl[15] = mk(4'b0001, 3'd4, 3'd6, 24'h00ABCD, 3'd0, 3'd0, 24'd0,      1'b0, 4'b0000);
    tbl[16] = mk(4'b0001, 3'd4, 3'd6, 24'h00ABCD, 3'd0, 3'd0, 24'd0,      1'b0, 4'b0001);
    tbl[17] = idle;
    tbl[18] = idle;
    tbl[18].req        = 4'b1100;
    tbl[18].cln[11:6]  = {3'd1, 3'd1};
    tbl[18].ai[95:48]  = {24'h999999, 24'h999999};

    clear_model();
    rst = 1'b1;
    drive(idle);
    repeat (2) @(posedge clk);
    #1;
    chk("reset ack", {188'd0, o_ack}, 192'd0);
    chk("reset busy", {191'd0, o_busy}, 192'd0);
    chk_sb("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d busy", i), {191'd0, o_busy}, {191'd0, tbl[i].busy});
      ack_q.push_back(tbl[i].ack);
      @(posedge clk);
      #1;
      exp_ack = ack_q.pop_front();
      chk($sformatf("row%0d ack", i), {188'd0, o_ack}, {188'd0, exp_ack});
      model_commit(exp_ack, tbl[i]);
      chk_sb($sformatf("row%0d", i));
    end

    // Reset while two requests are pending: nothing commits, everything clears at once.
    v = mk(4'b0011, 3'd1, 3'd0, 24'hAAAAAA, 3'd1, 3'd1, 24'hBBBBBB, 1'b1, 4'b0001);
    @(negedge clk);
    drive(v);
    #1;
    chk("midrst busy before", {191'd0, o_busy}, 192'd1);
    rst = 1'b1;
    #1;
    clear_model();
    chk("midrst async ack", {188'd0, o_ack}, 192'd0);
    chk_sb("midrst async");
    @(posedge clk);
    #1;
    chk("midrst held ack", {188'd0, o_ack}, 192'd0);
    chk_sb("midrst held");
    @(negedge clk);
    rst = 1'b0;
    ack_q.push_back(4'b0001);
    @(posedge clk);
    #1;
    exp_ack = ack_q.pop_front();
    chk("post-rst ptr0 ack", {188'd0, o_ack}, {188'd0, exp_ack});
    model_commit(exp_ack, v);
    chk_sb("post-rst first");
    @(negedge clk);
    v.req = 4'b0010;
    drive(v);
    ack_q.push_back(4'b0010);
    @(posedge clk);
    #1;
    exp_ack = ack_q.pop_front();
    chk("post-rst second ack", {188'd0, o_ack}, {188'd0, exp_ack});
    model_commit(exp_ack, v);
    chk_sb("post-rst second");
    chk("post-rst word1", {168'd0, o_sb_1[47:24]}, {168'd0, 24'hBBBBBB});
    @(negedge clk);
    drive(idle);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/intercpu_sb_write_arb.md
Name: intercpu_sb_write_arb

Overview:
- Holds the shared-B (SB) register clusters for the inter-CPU communication section and owns their only write port.
- Accepts "SBj <- Ai" write requests from up to four CPUs and arbitrates them round-robin, one write per clock.
- Presents each cluster as a registered 192-bit flattened vector for the cluster read multiplexer: word j occupies bits [24j+23:24j].

Parameters:
- NCPU, 2, number of requesting CPUs (1..4); request lanes at index >= NCPU are ignored.
- NCLUST, 5, number of implemented clusters (1..5); clusters numbered 1..NCLUST; cluster 0 means "no cluster".

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_req  in  4  per-CPU write request, bit k = CPU k
- i_cln  in  12  per-CPU cluster number, 3 bits per CPU, [3k+2:3k]
- i_j  in  12  per-CPU SB register index, 3 bits per CPU
- i_ai  in  96  per-CPU write data, 24 bits per CPU, [24k+23:24k]
- o_ack  out  4  one-cycle write acknowledge, bit k = CPU k
- o_sb_1 .. o_sb_5  out  192 each  cluster 1..5 SB contents, flattened
- o_busy  out  1  1 when any valid request lost arbitration this cycle

Behaviour:
- Reset (async, rst=1): all SB words of every cluster = 0; o_ack = 0; round-robin pointer = CPU 0; o_busy = 0.
- Eligibility in cycle N: i_req[k]=1, k<NCPU, and o_ack[k]=0 in cycle N. The o_ack mask stops a request still held in its ack cycle from being written twice.
- Arbitration: combinational round-robin over eligible lanes, starting at the pointer. At most one winner w per cycle.
- Commit at edge ending cycle N:
  - if 1<=cln[w]<=NCLUST, cluster cln[w] word j[w] <= ai[w];
  - o_ack[w] <= 1 and all other o_ack bits <= 0;
  - pointer <= (w+1) mod NCPU.
- No eligible lane: o_ack <= 0; pointer unchanged; no SB change.
- Latency: request seen in cycle N; new value visible on o_sb_* and o_ack[w]=1 both in cycle N+1.
- Requester handshake: hold i_req/i_cln/i_j/i_ai stable until o_ack[k]=1; drop i_req or present the next request in the ack cycle. A new request presented in the ack cycle becomes eligible from cycle N+2.
- Invalid cluster (cln=0 or cln>NCLUST): acknowledged normally, consumes its arbitration slot, no register changes.
- Outputs o_sb_k for k>NCLUST are held 0.
- Two CPUs writing the same cluster/word: both are serialised in round-robin order; the last acked value persists.
- o_busy (combinational) = 1 when the count of eligible lanes >= 2.
- rst asserted mid-handshake: pending requests are lost, no ack is issued, all registers clear immediately. Requesters re-present after release.
- The whole block is a single clock domain. Nothing is combinational from i_* to o_sb_*.

Test Plan:
- Reset, then CPU0 writes cln=1, j=3, ai=24'hABCDEF -> o_ack=4'b0001 next cycle; o_sb_1[95:72]=24'hABCDEF; all other bits 0.
- CPU0 and CPU1 request together, pointer=0: CPU0 writes cln=2, j=0, 24'h000111; CPU1 writes cln=2, j=7, 24'h777000 ->
  - cycle+1: ack=0001, o_busy was 1;
  - cycle+2: ack=0010;
  - o_sb_2[23:0]=000111 and o_sb_2[191:168]=777000.
- Same-word collision: CPU0 writes cln=5, j=4, 24'h111111; CPU1 writes cln=5, j=4, 24'h222222; pointer=1 -> CPU1 acked first, then CPU0; final o_sb_5[119:96]=24'h111111.
- CPU1 requests cln=0, j=2, 24'hFFFFFF -> ack asserted one cycle; every o_sb_* unchanged. Repeat with cln=6 at NCLUST=5: same result.
- Held request: CPU0 keeps i_req=1 with an identical payload for 3 cycles -> exactly one write; ack pattern 1,0,1 re-writes the same value harmlessly. Bench checks that no double write occurs within an ack cycle.
- Reset mid-operation: CPU0 and CPU1 pending, rst pulsed for 1 cycle before any commit -> all o_sb_*=0, o_ack=0; after release the arbitration pointer starts at CPU 0.
